// File: rtl/ln_pkg.sv
// LayerNorm shared types and constants.
// Imported by the Stage 3 issuer and its row buffer.
package ln_pkg;

  localparam int N_CH = 64;
  localparam int DW   = 16;
  localparam int MW   = 32;
  localparam int IW   = 17;
  localparam int AW   = $clog2(N_CH);
  localparam int RW   = $clog2(N_CH * DW);

  localparam logic [DW-1:0] LN_ONE_Q10 = 16'd1024;

  typedef logic [N_CH*DW-1:0] row_t;

  function automatic logic [RW-1:0] gb_slice(
    input logic [AW-1:0] addr
  );
    return RW'(addr) * RW'(DW);
  endfunction

endpackage

// File: rtl/ln_row_fifo.sv
// Raw-row FIFO for the Stage 3 issuer.
// Callers gate push/pop with full/empty.
module ln_row_fifo
  import ln_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  row_t                       i_wdata,
  output row_t                       o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  row_t          mem [DEPTH];

  // row storage, written at the tail
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_push) begin
      mem[wr_ptr] <= i_wdata;
    end
  end

  // pointers wrap naturally; count tracks push/pop balance
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (i_push) wr_ptr <= wr_ptr + PW'(1);
      if (i_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (i_push && !i_pop)
        o_count <= o_count + CW'(1);
      else if (!i_push && i_pop)
        o_count <= o_count - CW'(1);
    end
  end

  assign o_rdata = mem[rd_ptr];
  assign o_full  = (o_count == CW'(DEPTH));
  assign o_empty = (o_count == '0);

endmodule

// File: rtl/ln_stage3_issuer.sv
// LayerNorm Stage 3 issuer: buffers raw rows,
// pairs them with stats, holds gamma/beta.
module ln_stage3_issuer
  import ln_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic                       i_raw_valid,
  input  logic [N_CH*DW-1:0]         i_raw_data_flat,
  output logic                       o_raw_ready,
  input  logic                       i_stat_valid,
  input  logic [MW-1:0]              i_mean,
  input  logic [IW-1:0]              i_inv_sqrt,
  output logic                       o_stat_ready,
  input  logic                       i_gb_wr_en,
  input  logic                       i_gb_sel,
  input  logic [AW-1:0]              i_gb_addr,
  input  logic [DW-1:0]              i_gb_data,
  output logic                       o_gb_err,
  output logic                       o_valid_trigger,
  output logic [MW-1:0]              o_mean,
  output logic [IW-1:0]              o_inv_sqrt,
  output logic [N_CH*DW-1:0]         o_raw_data_flat,
  output logic [N_CH*DW-1:0]         o_gamma_flat,
  output logic [N_CH*DW-1:0]         o_beta_flat,
  output logic [$clog2(DEPTH+1)-1:0] o_occupancy,
  output logic [15:0]                o_row_cnt
);

  logic push;
  logic issue;
  logic full;
  logic empty;
  logic gb_ok;
  row_t head;
  row_t gamma_q;
  row_t beta_q;

  assign o_raw_ready  = i_en && !full;
  assign o_stat_ready = i_en && !empty;
  assign push  = i_raw_valid && o_raw_ready;
  assign issue = i_stat_valid && o_stat_ready;
  // params only change while no row is in flight
  assign gb_ok = i_en && i_gb_wr_en && empty && !issue;

  ln_row_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (issue),
    .i_wdata (i_raw_data_flat),
    .o_rdata (head),
    .o_count (o_occupancy),
    .o_full  (full),
    .o_empty (empty)
  );

  // issue register: trigger holds while frozen
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_trigger <= 1'b0;
      o_mean          <= '0;
      o_inv_sqrt      <= '0;
      o_raw_data_flat <= '0;
      o_row_cnt       <= '0;
    end else if (i_en) begin
      o_valid_trigger <= issue;
      if (issue) begin
        o_mean          <= i_mean;
        o_inv_sqrt      <= i_inv_sqrt;
        o_raw_data_flat <= head;
        o_row_cnt       <= o_row_cnt + 16'd1;
      end
    end
  end

  // gamma/beta file with rejected-write pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gamma_q  <= {N_CH{LN_ONE_Q10}};
      beta_q   <= '0;
      o_gb_err <= 1'b0;
    end else begin
      o_gb_err <= i_en && i_gb_wr_en && !gb_ok;
      if (gb_ok) begin
        if (i_gb_sel)
          beta_q[gb_slice(i_gb_addr) +: DW]  <= i_gb_data;
        else
          gamma_q[gb_slice(i_gb_addr) +: DW] <= i_gb_data;
      end
    end
  end

  assign o_gamma_flat = gamma_q;
  assign o_beta_flat  = beta_q;

endmodule

// File: tb/tb_ln_stage3_issuer.sv
// Scoreboard bench for ln_stage3_issuer.
// Directed rows/stats; monitor pops on fresh triggers.
module tb_ln_stage3_issuer;
  import ln_pkg::*;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  bit                run = 1'b0;
  logic              i_rst_n = 1'b1;
  logic              i_en = 1'b0;
  logic              i_raw_valid = 1'b0;
  row_t              i_raw_data_flat = '0;
  logic              o_raw_ready;
  logic              i_stat_valid = 1'b0;
  logic [MW-1:0]     i_mean = '0;
  logic [IW-1:0]     i_inv_sqrt = '0;
  logic              o_stat_ready;
  logic              i_gb_wr_en = 1'b0;
  logic              i_gb_sel = 1'b0;
  logic [AW-1:0]     i_gb_addr = '0;
  logic [DW-1:0]     i_gb_data = '0;
  logic              o_gb_err;
  logic              o_valid_trigger;
  logic [MW-1:0]     o_mean;
  logic [IW-1:0]     o_inv_sqrt;
  row_t              o_raw_data_flat;
  row_t              o_gamma_flat;
  row_t              o_beta_flat;
  logic [2:0]        o_occupancy;
  logic [15:0]       o_row_cnt;

  ln_stage3_issuer #(.DEPTH(DEPTH)) dut (
    .i_clk           (clk),
    .i_rst_n         (i_rst_n),
    .i_en            (i_en),
    .i_raw_valid     (i_raw_valid),
    .i_raw_data_flat (i_raw_data_flat),
    .o_raw_ready     (o_raw_ready),
    .i_stat_valid    (i_stat_valid),
    .i_mean          (i_mean),
    .i_inv_sqrt      (i_inv_sqrt),
    .o_stat_ready    (o_stat_ready),
    .i_gb_wr_en      (i_gb_wr_en),
    .i_gb_sel        (i_gb_sel),
    .i_gb_addr       (i_gb_addr),
    .i_gb_data       (i_gb_data),
    .o_gb_err        (o_gb_err),
    .o_valid_trigger (o_valid_trigger),
    .o_mean          (o_mean),
    .o_inv_sqrt      (o_inv_sqrt),
    .o_raw_data_flat (o_raw_data_flat),
    .o_gamma_flat    (o_gamma_flat),
    .o_beta_flat     (o_beta_flat),
    .o_occupancy     (o_occupancy),
    .o_row_cnt       (o_row_cnt)
  );

  always #5 if (run) clk = ~clk;

  typedef struct packed {
    logic [MW-1:0] m;
    logic [IW-1:0] s;
    row_t          r;
  } exp_t;

  exp_t          sb[$];
  row_t          mq[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  logic          exp_trig;
  logic [15:0]   m_cnt;
  row_t          g_m;
  row_t          b_m;
  logic [MW-1:0] last_mean;
  logic [IW-1:0] last_inv;
  row_t          last_raw;

  function automatic row_t mk_row(input int base);
    row_t r;
    for (int c = 0; c < N_CH; c++)
      r[DW*c +: DW] = DW'(base + c);
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_row(input string nm,
                         input row_t act,
                         input row_t exp);
    bit done;
    n_cmp++;
    done = 0;
    if (act !== exp) begin
      n_fail++;
      for (int c = 0; c < N_CH; c++) begin
        if (!done && act[DW*c +: DW] !== exp[DW*c +: DW]) begin
          done = 1;
          $display("FAIL %s lane %0d: got %0h want %0h",
                   nm, c, act[DW*c +: DW], exp[DW*c +: DW]);
        end
      end
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    exp_trig  = 1'b0;
    m_cnt     = '0;
    g_m       = {N_CH{LN_ONE_Q10}};
    b_m       = '0;
    last_mean = '0;
    last_inv  = '0;
    last_raw  = '0;
  endtask

  // one clock: pre-edge ready checks, model update, post-edge checks
  task automatic step();
    logic rr, sr, push, iss, ok, err;
    exp_t e;
    #1;
    rr = i_en && (mq.size() < DEPTH);
    sr = i_en && (mq.size() != 0);
    chk("raw_ready", 64'(o_raw_ready), 64'(rr));
    chk("stat_ready", 64'(o_stat_ready), 64'(sr));
    chk("occupancy", 64'(o_occupancy), 64'(mq.size()));
    push = i_raw_valid && rr;
    iss  = i_stat_valid && sr;
    ok   = i_en && i_gb_wr_en && (mq.size() == 0) && !iss;
    err  = i_en && i_gb_wr_en && !ok;
    @(posedge clk);
    if (iss) begin
      last_raw  = mq.pop_front();
      last_mean = i_mean;
      last_inv  = i_inv_sqrt;
      e.m = i_mean;
      e.s = i_inv_sqrt;
      e.r = last_raw;
      sb.push_back(e);
      m_cnt = m_cnt + 16'd1;
    end
    if (push) mq.push_back(i_raw_data_flat);
    if (ok) begin
      if (i_gb_sel) b_m[DW*int'(i_gb_addr) +: DW] = i_gb_data;
      else          g_m[DW*int'(i_gb_addr) +: DW] = i_gb_data;
    end
    if (i_en) exp_trig = iss;
    #2;
    chk("trigger", 64'(o_valid_trigger), 64'(exp_trig));
    chk("gb_err", 64'(o_gb_err), 64'(err));
    chk("row_cnt", 64'(o_row_cnt), 64'(m_cnt));
    chk("hold_mean", 64'(o_mean), 64'(last_mean));
    chk("hold_inv", 64'(o_inv_sqrt), 64'(last_inv));
    chk_row("hold_raw", o_raw_data_flat, last_raw);
    chk_row("gamma", o_gamma_flat, g_m);
    chk_row("beta", o_beta_flat, b_m);
  endtask

  // monitor: a trigger seen after an enabled edge is a new issue
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (i_rst_n && i_en && o_valid_trigger) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected: got trigger want none");
        end else begin
          e = sb.pop_front();
          chk("sb_mean", 64'(o_mean), 64'(e.m));
          chk("sb_inv", 64'(o_inv_sqrt), 64'(e.s));
          chk_row("sb_raw", o_raw_data_flat, e.r);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] t;
    model_reset();
    // 1: reset with clock stopped
    #1 i_rst_n = 1'b0;
    #2;
    chk("rst_trigger", 64'(o_valid_trigger), 64'd0);
    chk("rst_occ", 64'(o_occupancy), 64'd0);
    chk_row("rst_gamma", o_gamma_flat, {N_CH{16'd1024}});
    chk_row("rst_beta", o_beta_flat, '0);
    chk("rst_row_cnt", 64'(o_row_cnt), 64'd0);
    #2 i_rst_n = 1'b1;
    i_en = 1'b1;
    run = 1'b1;
    @(posedge clk);
    #2;

    // 2: three rows, back-to-back stats
    i_raw_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      i_raw_data_flat = mk_row(100 + k);
      step();
    end
    i_raw_valid = 1'b0;
    i_stat_valid = 1'b1;
    i_inv_sqrt = 17'd1024;
    for (int k = 1; k <= 3; k++) begin
      i_mean = MW'(10 * k);
      step();
    end
    i_stat_valid = 1'b0;
    chk("t2_row_cnt", 64'(o_row_cnt), 64'd3);
    t = o_raw_data_flat[15:0];
    chk("t2_last_ch0", 64'(t), 64'd103);
    step();
    chk("t2_occ", 64'(o_occupancy), 64'd0);

    // 3: overfill, then wrap
    i_raw_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      i_raw_data_flat = mk_row(200 + 16 * k);
      step();
    end
    chk("t3_full_ready", 64'(o_raw_ready), 64'd0);
    i_stat_valid = 1'b1;
    i_mean = 32'hFFFF_FC18;
    i_inv_sqrt = 17'h1_0001;
    step();
    i_stat_valid = 1'b0;
    step();
    i_raw_valid = 1'b0;
    i_stat_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_mean = MW'(1001 + k);
      i_inv_sqrt = IW'(512 + k);
      step();
    end
    i_stat_valid = 1'b0;
    step();

    // 4: freeze with trigger pending
    i_raw_valid = 1'b1;
    i_raw_data_flat = mk_row(300);
    step();
    i_raw_data_flat = mk_row(400);
    step();
    i_raw_valid = 1'b0;
    i_stat_valid = 1'b1;
    i_mean = 32'd77;
    i_inv_sqrt = 17'd2048;
    step();
    i_en = 1'b0;
    i_raw_valid = 1'b1;
    i_raw_data_flat = mk_row(500);
    i_mean = 32'd88;
    for (int k = 0; k < 3; k++) step();
    chk("t4_held_trig", 64'(o_valid_trigger), 64'd1);
    chk("t4_held_occ", 64'(o_occupancy), 64'd1);
    i_en = 1'b1;
    i_raw_valid = 1'b0;
    i_stat_valid = 1'b0;
    step();
    chk("t4_clear", 64'(o_valid_trigger), 64'd0);
    i_stat_valid = 1'b1;
    i_mean = 32'd99;
    step();
    i_stat_valid = 1'b0;
    step();

    // 5: parameter writes, idle then busy
    i_gb_wr_en = 1'b1;
    i_gb_sel = 1'b0;
    i_gb_addr = 6'd5;
    i_gb_data = 16'd512;
    step();
    i_gb_sel = 1'b1;
    i_gb_data = 16'hFFFD;
    step();
    i_gb_wr_en = 1'b0;
    chk("t5_gamma5", 64'(o_gamma_flat[95:80]), 64'd512);
    chk("t5_beta5", 64'(o_beta_flat[95:80]), 64'hFFFD);
    i_raw_valid = 1'b1;
    i_raw_data_flat = mk_row(600);
    step();
    i_raw_data_flat = mk_row(700);
    step();
    i_raw_valid = 1'b0;
    i_gb_wr_en = 1'b1;
    i_gb_sel = 1'b0;
    i_gb_data = 16'd7;
    step();
    chk("t5_err_pulse", 64'(o_gb_err), 64'd1);
    i_gb_wr_en = 1'b0;
    step();
    chk("t5_err_clear", 64'(o_gb_err), 64'd0);
    chk("t5_gamma_kept", 64'(o_gamma_flat[95:80]), 64'd512);
    i_stat_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_mean = MW'(-5 - k);
      step();
    end
    i_stat_valid = 1'b0;
    step();

    // 6: async reset mid-stream
    i_raw_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_raw_data_flat = mk_row(800 + 64 * k);
      step();
    end
    i_raw_data_flat = mk_row(1000);
    i_stat_valid = 1'b1;
    i_mean = 32'd55;
    step();
    chk("t6_pre_occ", 64'(o_occupancy), 64'd3);
    chk("t6_pre_trig", 64'(o_valid_trigger), 64'd1);
    i_rst_n = 1'b0;
    #1;
    chk("t6_trig", 64'(o_valid_trigger), 64'd0);
    chk("t6_occ", 64'(o_occupancy), 64'd0);
    chk("t6_gamma5", 64'(o_gamma_flat[95:80]), 64'd1024);
    chk("t6_row_cnt", 64'(o_row_cnt), 64'd0);
    i_raw_valid = 1'b0;
    i_stat_valid = 1'b0;
    model_reset();
    #2 i_rst_n = 1'b1;
    @(posedge clk);
    #2;
    step();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
